// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: decodes 'W'/'R' command frames arriving on an 8N1 serial line,
// runs one 32-bit bus transfer as initiator, and answers with a short reply frame.
module uart_bus_master #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BUS_TIMEOUT  = 1023,
    parameter int BYTE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_w_data,
    output logic        bus_w_en,
    output logic        bus_r_en,
    input  logic [31:0] bus_r_data,
    input  logic        bus_ready,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam int GW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BUS_LAST  = BW'(BUS_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(BYTE_TIMEOUT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    logic          rx_meta_q, rx_sync_q, rx_last_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_ready, tx_load;

    state_t        state_q, state_d;
    logic          is_write_q, is_write_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          w_en_q, w_en_d;
    logic          r_en_q, r_en_d;
    logic [BW-1:0] bus_cnt_q, bus_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [39:0]   resp_buf_q, resp_buf_d;
    logic [2:0]    resp_cnt_q, resp_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_last_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            w_en_q     <= 1'b0;
            r_en_q     <= 1'b0;
            bus_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            resp_buf_q <= '0;
            resp_cnt_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_last_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            w_en_q     <= w_en_d;
            r_en_q     <= r_en_d;
            bus_cnt_q  <= bus_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            resp_buf_q <= resp_buf_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    // Start needs a real falling edge, so a line held low after a framing error is not re-read as a start bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q && rx_last_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_valid   = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // A new byte may be loaded in the final stop-bit cycle so reply bytes go out back-to-back.
    assign tx_ready = (tx_state_q == TX_IDLE) ||
                      (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_load) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = resp_buf_q[39:32];
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_load) begin
                        tx_state_d = TX_START;
                        tx_shift_d = resp_buf_q[39:32];
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
        tx_d = 1'b1;
        if (tx_state_d == TX_START) begin
            tx_d = 1'b0;
        end else if (tx_state_d == TX_DATA) begin
            tx_d = tx_shift_d[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        w_en_d     = w_en_q;
        r_en_d     = r_en_q;
        bus_cnt_d  = bus_cnt_q;
        gap_cnt_d  = '0;
        resp_buf_d = resp_buf_q;
        resp_cnt_d = resp_cnt_q;
        tx_load    = 1'b0;

        // Gap only accumulates while the receiver is fully idle inside a partial frame.
        if ((state_q == S_ADDR || state_q == S_DATA) && !rx_valid && rx_state_q == RX_IDLE) begin
            gap_cnt_d = (gap_cnt_q == GAP_LIMIT) ? gap_cnt_q : gap_cnt_q + GW'(1);
        end

        if (resp_cnt_q != 3'd0 && tx_ready) begin
            tx_load    = 1'b1;
            resp_buf_d = {resp_buf_q[31:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    byte_idx_d = '0;
                    if (rx_shift_q == 8'h57) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else if (rx_shift_q == 8'h52) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        resp_buf_d = {8'h3F, 32'h0};
                        resp_cnt_d = 3'd1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d     = {addr_q[23:0], rx_shift_q};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        bus_cnt_d = '0;
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                            r_en_d  = 1'b1;
                        end
                    end
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wdata_d    = {wdata_q[23:0], rx_shift_q};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d   = S_BUS;
                        w_en_d    = 1'b1;
                        bus_cnt_d = '0;
                    end
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (bus_ready) begin
                    w_en_d     = 1'b0;
                    r_en_d     = 1'b0;
                    state_d    = S_RESP;
                    resp_buf_d = is_write_q ? {8'h4B, 32'h0} : {8'h4B, bus_r_data};
                    resp_cnt_d = is_write_q ? 3'd1 : 3'd5;
                end else if (bus_cnt_q == BUS_LAST) begin
                    w_en_d     = 1'b0;
                    r_en_d     = 1'b0;
                    state_d    = S_RESP;
                    resp_buf_d = {8'h45, 32'h0};
                    resp_cnt_d = 3'd1;
                end else begin
                    bus_cnt_d = bus_cnt_q + BW'(1);
                end
            end
            S_RESP: begin
                if (resp_cnt_q == 3'd0 && tx_state_q == TX_IDLE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx         = tx_q;
    assign bus_addr   = addr_q;
    assign bus_w_data = wdata_q;
    assign bus_w_en   = w_en_q;
    assign bus_r_en   = r_en_q;
    assign busy       = (state_q != S_IDLE) || (resp_cnt_q != 3'd0) || (tx_state_q != TX_IDLE);

endmodule
